// File: rtl/reset_clock_manager_pkg.sv
// rcm_pkg: reset-cause encodings and sequencer state type shared by the reset manager.
package rcm_pkg;
  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  typedef enum logic [1:0] {HOLD, COUNT, RUN} state_e;
endpackage

// File: rtl/reset_clock_manager_if.sv
// reset_clock_manager_if: reset requests in, divided clock and staggered resets out.
interface reset_clock_manager_if #(parameter int NUM_RESETS = 2);
  logic                  ext_reset;
  logic                  soft_reset_req;
  logic                  clk_o;
  logic                  clk_en;
  logic [NUM_RESETS-1:0] reset_o;
  logic                  ready;
  logic [1:0]            reset_cause;
  modport master (input ext_reset, soft_reset_req, output clk_o, clk_en, reset_o, ready, reset_cause);
  modport slave (output ext_reset, soft_reset_req, input clk_o, clk_en, reset_o, ready, reset_cause);
endinterface

// File: rtl/reset_clock_manager_sync_debounce.sv
// reset_sync_debounce: multi-flop synchroniser followed by a consecutive-high debounce counter.
module reset_sync_debounce #(
  parameter int STAGES          = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int CW = DEBOUNCE_CYCLES > 0 ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  logic [STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              s;
  assign s = sync_q[STAGES-1];
  assign q = s && cnt_q == CW'(DEBOUNCE_CYCLES);
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    cnt_d  = !s ? '0 : cnt_q == CW'(DEBOUNCE_CYCLES) ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
endmodule

// File: rtl/reset_clock_manager.sv
// reset_clock_manager: divided clock/enable plus merged, staggered reset release with cause capture.
module reset_clock_manager
  import rcm_pkg::*;
#(
  parameter int DIV_RATIO       = 2,
  parameter int CYCLES          = 20,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int NUM_RESETS      = 2,
  parameter int STAGGER         = 4
) (
  input logic                   clk,
  input logic                   reset,
  reset_clock_manager_if.master bus
);
  localparam int HALF = DIV_RATIO / 2;
  localparam int DW   = $clog2(DIV_RATIO);
  localparam int MAX  = CYCLES + (NUM_RESETS - 1) * STAGGER;
  localparam int SW   = MAX > 0 ? $clog2(MAX + 1) : 1;
  if (DIV_RATIO < 2 || DIV_RATIO % 2 != 0) begin : g_bad_div
    $error("reset_clock_manager: DIV_RATIO must be even and >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_clock_manager: SYNC_STAGES must be >= 2");
  end
  if (NUM_RESETS < 1) begin : g_bad_num
    $error("reset_clock_manager: NUM_RESETS must be >= 1");
  end
  logic [DW-1:0]         div_q, div_d;
  logic                  clk_o_q, clk_o_d, clk_en_q, clk_en_d;
  logic                  released, ext_active, any_active;
  state_e                state_q, state_d;
  logic [SW-1:0]         seq_q, seq_d;
  logic [NUM_RESETS-1:0] rst_o_q, rst_o_d;
  logic [1:0]            cause_q, cause_d;
  reset_sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_rel (
    .clk(clk), .rst_n(reset), .d(1'b1), .q(released)
  );
  reset_sync_debounce #(.STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext (
    .clk(clk), .rst_n(reset), .d(bus.ext_reset), .q(ext_active)
  );
  assign any_active = !released || ext_active || bus.soft_reset_req;
  // clk_o and clk_en are registered so both sit at 0 throughout power-on reset
  always_comb begin
    div_d    = div_q == DW'(DIV_RATIO - 1) ? '0 : div_q + 1'b1;
    clk_o_d  = div_d >= DW'(HALF);
    clk_en_d = div_d == DW'(HALF - 1);
  end
  always_comb begin
    seq_d   = any_active ? '0 : seq_q == SW'(MAX) ? seq_q : seq_q + 1'b1;
    state_d = any_active ? HOLD : seq_d == SW'(MAX) ? RUN : COUNT;
    cause_d = !released ? CAUSE_POR : ext_active ? CAUSE_EXT : bus.soft_reset_req ? CAUSE_SOFT : cause_q;
    rst_o_d = '1;
    for (int i = 0; i < NUM_RESETS; i++) rst_o_d[i] = any_active || int'(seq_d) < CYCLES + i * STAGGER;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      div_q    <= '0;
      clk_o_q  <= 1'b0;
      clk_en_q <= 1'b0;
      state_q  <= HOLD;
      seq_q    <= '0;
      rst_o_q  <= '1;
      cause_q  <= CAUSE_POR;
    end else begin
      div_q    <= div_d;
      clk_o_q  <= clk_o_d;
      clk_en_q <= clk_en_d;
      state_q  <= state_d;
      seq_q    <= seq_d;
      rst_o_q  <= rst_o_d;
      cause_q  <= cause_d;
    end
  assign bus.clk_o       = clk_o_q;
  assign bus.clk_en      = clk_en_q;
  assign bus.reset_o     = rst_o_q;
  assign bus.ready       = state_q == RUN;
  assign bus.reset_cause = cause_q;
endmodule

// File: doc/reset_clock_manager.md
Name: reset_clock_manager

Overview:
Parametrised clock-and-reset generator for the FPGA board tops. It replaces the ad-hoc divide-by-2 toggle and the single boot-reset counter.
- Produces a divided 50%-duty clock plus a matching clock-enable strobe.
- Merges three reset sources (power-on, debounced board button, SoC soft-reset request).
- Releases NUM_RESETS active-high reset outputs in a staggered order and records the last reset cause.
Sits directly under each board top, feeding Risco_5_SOC and peripherals.

Parameters:
DIV_RATIO, 2, clk cycles per clk_o period; even, >=2
CYCLES, 20, minimum clk cycles every reset output stays asserted after all sources release
SYNC_STAGES, 2, flops in reset-release and ext_reset synchronisers; >=2
DEBOUNCE_CYCLES, 0, consecutive synced-high cycles before ext_reset counts; 0 = no debounce
NUM_RESETS, 2, number of reset outputs; >=1
STAGGER, 4, extra clk cycles between release of reset_o[i] and reset_o[i+1]

Ports:
clk  in  1  board clock
reset  in  1  asynchronous, active-low, power-on reset
ext_reset  in  1  board reset button; asynchronous, active-high
soft_reset_req  in  1  single-cycle request from SoC, synchronous to clk
clk_o  out  1  divided clock, 50% duty
clk_en  out  1  one-clk pulse; clk_o rises at the next clk edge
reset_o  out  NUM_RESETS  active-high domain resets; bit 0 released first
ready  out  1  all reset_o deasserted
reset_cause  out  2  00 power-on, 01 external, 10 soft; held until next reset

Behaviour:
- While reset=0 (asynchronous): clk_o=0, clk_en=0, reset_o=all 1, ready=0, reset_cause=00, all counters and synchronisers cleared.
- Divider:
  - Counter runs from the first posedge after reset releases, independent of the reset sequence, so domains are clocked while held in reset.
  - clk_o toggles every DIV_RATIO/2 clk cycles; the first rise is DIV_RATIO/2 posedges after release.
  - clk_en is high exactly in the clk cycle preceding each clk_o rising edge.
- Release sync: reset deassertion passes through SYNC_STAGES flops. The synced release goes high at posedge number SYNC_STAGES, counting the first posedge after reset rises as 1.
- Ext path:
  - ext_reset passes through SYNC_STAGES flops.
  - A debounce counter counts consecutive synced-high cycles and clears on any low.
  - The source is active once count >= DEBOUNCE_CYCLES, and stays active while synced-high.
  - Release is immediate on synced low.
- Sequencer FSM:
  - HOLD: any source active; seq_cnt=0; all reset_o=1.
  - COUNT: no source active; seq_cnt increments each clk; reset_o[i] falls at the posedge where seq_cnt reaches CYCLES+i*STAGGER.
  - RUN: seq_cnt saturated at CYCLES+(NUM_RESETS-1)*STAGGER; ready=1, set on the same edge reset_o[NUM_RESETS-1] falls.
  - Any source active in COUNT or RUN goes to HOLD on the next posedge; all reset_o=1 and ready=0 on that edge. This restarts a sequence already in progress.
- Power-on timing: reset_o[i] falls at posedge SYNC_STAGES+CYCLES+i*STAGGER.
- Soft reset:
  - soft_reset_req sampled high at posedge P gives HOLD after P, then COUNT.
  - With req low after P, reset_o[i] falls at P+CYCLES+i*STAGGER.
  - Accepted in any state, including mid-sequence (sequence restarts).
- reset_cause:
  - Written on entry to HOLD from an external or soft source.
  - External and soft on the same edge: 01 wins.
  - Power-on always gives 00.
  - Unchanged by HOLD re-entry from the same still-active source.
- Width rule: seq_cnt is $clog2(CYCLES+(NUM_RESETS-1)*STAGGER+1) bits, and must never wrap.
- Parameter checks: illegal values (odd DIV_RATIO, SYNC_STAGES<2) trigger an elaboration-time error.

Decomposition:
- Shared package rcm_pkg holds the cause encodings (CAUSE_POR=2'b00, CAUSE_EXT=2'b01, CAUSE_SOFT=2'b10) and the FSM state typedef (HOLD, COUNT, RUN).
- One sub-module: reset_sync_debounce, holding the SYNC_STAGES synchroniser plus debounce counter. It is instantiated for ext_reset; the release synchroniser uses the same module with DEBOUNCE_CYCLES=0.

Test Plan:
All scenarios use defaults except DIV_RATIO=4, NUM_RESETS=2.
1. Power-on: release reset, no other stimulus -> reset_o[0] falls at posedge 22, reset_o[1] and ready at posedge 26, reset_cause=00.
2. Divider: after reset, count clk edges -> clk_o period 4, first rise at posedge 2; clk_en high once per 4 cycles, one cycle before each rise; divider runs while reset_o=11.
3. Soft reset in RUN: soft_reset_req pulse at posedge P -> reset_o=11 and ready=0 after P; reset_o[0] falls at P+20, reset_o[1] at P+24; reset_cause=10.
4. Debounce: DEBOUNCE_CYCLES=8; 5-cycle ext_reset glitch -> no reset. 20-cycle press -> reset_o=11 after 2+8 cycles; reset_o[0] falls 20 cycles after synced release; reset_cause=01.
5. Mid-sequence restart: soft_reset_req at seq_cnt=10 -> seq_cnt back to 0; reset_o[0] falls 20 cycles later, not 10.
6. Simultaneous events: ext_reset (DEBOUNCE_CYCLES=0) and soft_reset_req recognised on the same edge -> reset_cause=01. Then async reset low mid-RUN -> all outputs at reset values immediately, without a clock edge.
